// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect-select encodings, fetch FSM states and
// the default reset fetch address.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    RST  = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10,
    KILL = 2'b11
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register: parks a fetched instruction and its PC+4 when
// the IF/ID register cannot accept it. Flush wins over load and drain.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcadd4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pcadd4
);

  // Skid entry: flush on redirect, capture on load, release on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      valid  <= 1'b0;
      // NOTE: data is reset too; one word is cheap and keeps X out of IF/ID.
      instr  <= '0;
      pcadd4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      instr  <= instr_in;
      pcadd4 <= pcadd4_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, req/ack
// instruction-memory port, skid buffer and the IF/ID pipeline register.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchPC,
  input  logic [31:0] JumpPC,
  input  logic [31:0] JrPC,
  input  logic        Stall,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IData,
  output logic        IdValid,
  output logic [31:0] IdInstr,
  output logic [31:0] IdPCADD4
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_add4;
  logic [31:0]  kill_addr, kill_addr_nxt;
  logic [31:0]  target;
  logic         redirect, accept, complete;
  logic         id_load, skid_load, skid_drain;
  logic         skid_valid;
  logic [31:0]  skid_instr, skid_pcadd4;

  assign pc_add4  = pc + 32'd4;
  assign redirect = (PCSrc != PC_SEQ);
  assign accept   = !IdValid || !Stall;

  // KILL keeps presenting the abandoned address until its ack arrives.
  assign IReq     = (state == REQ) || (state == KILL);
  assign IAddr    = (state == KILL) ? kill_addr : pc;
  assign complete = IReq && IAck;

  // Redirect target select, forced to a word boundary.
  always_comb begin
    target = pc_add4;
    case (pc_src_e'(PCSrc))
      PC_BR:   target = word_align(BranchPC);
      PC_J:    target = word_align(JumpPC);
      PC_JR:   target = word_align(JrPC);
      default: target = pc_add4;
    endcase
  end

  // Next-state, next-PC and datapath enables; redirect overrides everything.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt     = state;
    pc_nxt        = pc;
    kill_addr_nxt = kill_addr;
    id_load       = 1'b0;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    if (redirect) begin
      pc_nxt = target;
      if (state == REQ && !IAck) begin
        state_nxt     = KILL;
        kill_addr_nxt = pc;
      end else if (state == KILL && !IAck) begin
        state_nxt = KILL;
      end else begin
        state_nxt = REQ;
      end
    end else begin
      case (state)
        RST: state_nxt = REQ;
        REQ: begin
          if (complete) begin
            pc_nxt = pc_add4;
            if (accept) begin
              id_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            skid_drain = 1'b1;
            state_nxt  = REQ;
          end
        end
        KILL: begin
          if (IAck) state_nxt = REQ;
        end
        default: state_nxt = RST;
      endcase
    end
  end

  // FSM state, PC and the address of a request being killed.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state     <= RST;
      pc        <= RESET_PC;
      kill_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      kill_addr <= kill_addr_nxt;
    end
  end

  // IF/ID register: fill from memory or skid, drop when consumed with no refill.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      IdValid  <= 1'b0;
      IdInstr  <= '0;
      IdPCADD4 <= '0;
    end else if (redirect) begin
      IdValid <= 1'b0;
    end else if (id_load) begin
      IdValid  <= 1'b1;
      IdInstr  <= IData;
      IdPCADD4 <= pc_add4;
    end else if (skid_drain) begin
      IdValid  <= 1'b1;
      IdInstr  <= skid_instr;
      IdPCADD4 <= skid_pcadd4;
    end else if (accept) begin
      IdValid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (Clk),
    .rst_n     (Clrn),
    .load      (skid_load),
    .drain     (skid_drain),
    .flush     (redirect),
    .instr_in  (IData),
    .pcadd4_in (pc_add4),
    .valid     (skid_valid),
    .instr     (skid_instr),
    .pcadd4    (skid_pcadd4)
  );

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage: holds the program counter, selects the next PC (sequential, branch, jump, register-jump), drives a req/ack instruction-memory port, and loads the IF/ID pipeline register. It sits directly upstream of the branch-offset and jump-target shifters. Its IdPCADD4 output is the PC+4 that the jump-target combiner concatenates with. The branch and jump targets built downstream come back through PCSrc to redirect fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (low 2 bits must be 00)
- Clk  in  1  clock, rising edge
- Clrn  in  1  asynchronous, active-low reset
- PCSrc  in  2  redirect select: 00 sequential, 01 branch, 10 jump, 11 register jump
- BranchPC  in  32  branch target
- JumpPC  in  32  jump target
- JrPC  in  32  register-jump target
- Stall  in  1  ID stage cannot accept a new instruction
- IReq  out  1  instruction request
- IAddr  out  32  request address, word aligned
- IAck  in  1  memory response; IData valid in the same cycle
- IData  in  32  instruction word
- IdValid  out  1  IF/ID holds a valid instruction
- IdInstr  out  32  IF/ID instruction
- IdPCADD4  out  32  IF/ID fetch address + 4

## Operation
- Redirect = (PCSrc != 00). The target is selected from BranchPC, JumpPC or JrPC, with bits [1:0] forced to 00.
- Memory protocol:
  - Once IReq is high, IAddr is held stable until a cycle with IAck=1.
  - A request completes in any cycle with IReq && IAck.
  - IAck is ignored while IReq=0.
- accept = !IdValid || !Stall. IF/ID loads only when accept=1. A stall with IdValid=0 does not block.
- PC register: it is the address of the next request and advances to PC+4 on every completed, non-discarded request. PC+4 wraps modulo 2^32.
- One-entry skid buffer (SkidValid, SkidInstr, SkidPCADD4) captures a completed response when accept=0.
- States:
  - RST: one cycle after Clrn rises. IReq=0. Goes to REQ.
  - REQ: IReq=1, IAddr=PC. On completion:
    - accept=1: load IF/ID (IdInstr=IData, IdPCADD4=PC+4, IdValid=1). Stay in REQ.
    - accept=0: load skid and go to HOLD.
  - HOLD: IReq=0. When accept=1, move skid into IF/ID, clear SkidValid, go to REQ.
  - KILL: IReq=1 with the old IAddr. The response is dropped on IAck, then go to REQ.
- Redirect, in any state, has priority over Stall and over any completing response:
  - Set PC to the target. Clear IdValid and SkidValid next cycle.
  - If state is REQ with IAck=0, go to KILL; otherwise go to REQ.
  - A response completing in the redirect cycle is discarded.
- A redirect while in KILL updates PC; the state stays KILL.
- Stall with IdValid=1 and no redirect: IF/ID holds all values.

## Timing
- Reset values (asynchronous, while Clrn=0):
  - PC=RESET_PC, state RST, SkidValid=0.
  - IReq=0, IAddr=RESET_PC.
  - IdValid=0, IdInstr=0, IdPCADD4=0.
- First IReq is in the second rising edge's cycle after Clrn deasserts.
- Zero-wait memory (IAck tied to IReq): one instruction per cycle. Request in cycle n gives IdValid in cycle n+1.
- Redirect in cycle n with no outstanding unacked request:
  - IdValid=0 in n+1 and IAddr=target in n+1.
  - Target instruction is in IF/ID in n+2 with zero-wait memory.
- Reset asserted mid-request abandons the request immediately. No response is held across reset.
- Instructions are never lost or duplicated across Stall, skid or HOLD.

## Structure
- Shared package cpu_pkg:
  - PCSrc encodings PC_SEQ, PC_BR, PC_J, PC_JR.
  - Fetch state encoding (RST, REQ, HOLD, KILL).
  - Default RESET_PC.
- Sub-module fetch_skid_buf: the one-entry skid register with load, drain and flush.
- Next-PC mux, PC register, FSM and IF/ID register live in the top.

## Test plan
- Reset: Clrn=0 mid-run → IReq=0, IdValid=0, IdInstr=0, IdPCADD4=0 immediately. After release: RST for one cycle, then IReq=1 with IAddr=0.
- Zero-wait streaming, IData=IAddr: IdInstr is 0, 4, 8, 12 on consecutive cycles, and IdPCADD4 is 4, 8, 12, 16.
- Two-wait memory, Stall raised while the request at 0x8 is outstanding:
  - Response goes to skid; state is HOLD with IReq=0.
  - When Stall drops, IdInstr=0x8 and the next IAddr is 0xC.
  - No duplicate and no gap.
- Branch redirect while unacked: PCSrc=01, BranchPC=0x100 during a request at 0x20 →
  - KILL; the 0x20 response is dropped and IdValid=0.
  - Next IAddr is 0x100 and IdInstr becomes the 0x100 word.
- Simultaneous events: PCSrc=10, JumpPC=0x0040_0003 with Stall=1 and IAck=1 in the same cycle →
  - Response discarded, IdValid=0 next cycle.
  - IAddr=0x0040_0000.
- Wrap: RESET_PC=32'hFFFF_FFFC → IdPCADD4=0 and the second IAddr is 0x0.
